// File: rtl/mops_sdo_responder.sv
// CANopen SDO expedited-transfer responder: serves ADC-channel reads and a
// 16-entry user register bank, answering after a fixed programmable delay.
module mops_sdo_responder #(
  parameter logic [6:0] NODE_ID  = 7'h00,
  parameter int         RESP_DLY = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [75:0] req_data,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] adc_data,
  output logic [75:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  adc_ch,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, WAIT, RESP} state_t;

  localparam logic [7:0]  DLY_LOAD = 8'(RESP_DLY - 1);
  localparam logic [10:0] REQ_COB  = 11'h600 + {4'h0, NODE_ID};
  localparam logic [10:0] RSP_COB  = 11'h580 + {4'h0, NODE_ID};

  state_t      state_reg, state_next;
  logic [75:0] req_reg;
  logic [75:0] rsp_reg;
  logic [7:0]  cnt_reg;
  logic [31:0] user_reg [16];
  logic [15:0] wr_en;

  logic [7:0]  cmd, sub;
  logic [15:0] idx;
  logic        frame_ok, is_adc_rd, is_reg_rd, is_reg_wr;
  logic [31:0] wr_value;
  logic [7:0]  rsp_cmd;
  logic [31:0] rsp_value;
  logic [75:0] rsp_frame;

  assign cmd       = req_reg[63:56];
  assign idx       = {req_reg[47:40], req_reg[55:48]};
  assign sub       = req_reg[39:32];
  assign frame_ok  = (req_reg[75:65] == REQ_COB) && !req_reg[64];
  assign is_adc_rd = (cmd == 8'h40) && (idx == 16'h2400) && (sub < 8'd36);
  assign is_reg_rd = (cmd == 8'h40) && (idx == 16'h2200) && (sub < 8'd16);
  assign is_reg_wr = (cmd == 8'h23) && (idx == 16'h2200) && (sub < 8'd16);
  // Payload bytes 4..7 carry the 32-bit value little-endian.
  assign wr_value  = {req_reg[7:0], req_reg[15:8], req_reg[23:16], req_reg[31:24]};

  always_comb begin
    rsp_cmd   = 8'h80;
    rsp_value = 32'h0602_0000;
    if (is_adc_rd) begin
      rsp_cmd   = 8'h43;
      rsp_value = {20'h0, adc_data};
    end else if (is_reg_rd) begin
      rsp_cmd   = 8'h43;
      rsp_value = user_reg[sub[3:0]];
    end else if (is_reg_wr) begin
      rsp_cmd   = 8'h60;
      rsp_value = 32'h0;
    end
    rsp_frame = {RSP_COB, 1'b0, rsp_cmd, req_reg[55:32],
                 rsp_value[7:0], rsp_value[15:8], rsp_value[23:16], rsp_value[31:24]};
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = DECODE;
      DECODE:  state_next = frame_ok ? EXEC : IDLE;
      EXEC:    state_next = WAIT;
      WAIT:    if (cnt_reg == 8'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      req_reg   <= '0;
      rsp_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) req_reg <= req_data;
      if (state_reg == EXEC) begin
        rsp_reg <= rsp_frame;
        cnt_reg <= DLY_LOAD;
      end else if (state_reg == WAIT && cnt_reg != 8'd0) begin
        cnt_reg <= cnt_reg - 8'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_wr_en
      assign wr_en[gi] = (state_reg == EXEC) && is_reg_wr && (sub[3:0] == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (rst) user_reg[i] <= '0;
      else if (wr_en[i]) user_reg[i] <= wr_value;
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = rsp_reg;
  assign adc_ch    = ((state_reg == EXEC || state_reg == WAIT || state_reg == RESP) && is_adc_rd)
                     ? sub[5:0] : 6'd0;

endmodule
